// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scan-code constants and prefix-state encoding
package ps2_pkg;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_P     = 8'h4D;
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} prefix_t;
endpackage

// File: rtl/ps2_flap_decoder_key_tracker.sv
// key_tracker: held flag for one key, pulses press on the first make only
module key_tracker (
    input  logic clock,
    input  logic reset,
    input  logic make,
    input  logic brk,
    output logic held,
    output logic press
);
    assign press = make && !held;
    // a make latches the key as held until its break arrives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) held <= 1'b0;
        else held <= brk ? 1'b0 : (make ? 1'b1 : held);
    end
endmodule

// File: rtl/ps2_flap_decoder.sv
// ps2_flap_decoder: turns PS/2 scan codes into flap requests and a pause level
module ps2_flap_decoder import ps2_pkg::*; #(
    parameter logic [7:0]  FLAP_CODE      = SC_SPACE,
    parameter logic [7:0]  PAUSE_CODE     = SC_P,
    parameter logic [23:0] HOLDOFF        = 24'd1_000_000,
    parameter logic [19:0] PREFIX_TIMEOUT = 20'd100_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_pressed,
    input  logic [7:0]  key_data,
    input  logic        flap_ack,
    output logic        flap_req,
    output logic        paused,
    output logic [15:0] flap_count
);
    prefix_t     state, state_nxt;
    logic [19:0] to_cnt;
    logic [23:0] holdoff;
    logic        make, brk, flap_held, flap_press, pause_held, pause_press, accept;
    assign make   = key_pressed && state == IDLE && key_data != SC_BREAK && key_data != SC_EXT;
    assign brk    = key_pressed && state == BRK;
    assign accept = flap_press && !paused && holdoff == 24'd0;
    key_tracker u_flap (
        .clock(clock), .reset(reset),
        .make(make && key_data == FLAP_CODE), .brk(brk && key_data == FLAP_CODE),
        .held(flap_held), .press(flap_press)
    );
    key_tracker u_pause (
        .clock(clock), .reset(reset),
        .make(make && key_data == PAUSE_CODE), .brk(brk && key_data == PAUSE_CODE),
        .held(pause_held), .press(pause_press)
    );
    // prefix decoding advances on strobes; a stalled prefix falls back to IDLE
    always_comb begin
        state_nxt = state;
        if (key_pressed)
            case (state)
                IDLE:    state_nxt = key_data == SC_BREAK ? BRK : (key_data == SC_EXT ? EXT : IDLE);
                EXT:     state_nxt = key_data == SC_BREAK ? EXT_BRK : IDLE;
                default: state_nxt = IDLE;
            endcase
        else if (state != IDLE && to_cnt == PREFIX_TIMEOUT)
            state_nxt = IDLE;
    end
    // prefix state and its idle-cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= (key_pressed || state_nxt == IDLE) ? '0 : to_cnt + 20'd1;
        end
    end
    // holdoff window, flap handshake (new flap beats ack), counter and pause toggle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            holdoff    <= '0;
            flap_req   <= 1'b0;
            flap_count <= '0;
            paused     <= 1'b0;
        end else begin
            holdoff    <= accept ? HOLDOFF : (holdoff != 24'd0 ? holdoff - 24'd1 : holdoff);
            flap_req   <= accept ? 1'b1 : (flap_ack ? 1'b0 : flap_req);
            flap_count <= flap_count + {15'd0, accept};
            paused     <= paused ^ pause_press;
        end
    end
    wire unused_ok = pause_held;
endmodule

// File: tb/tb_ps2_flap_decoder.sv
// tb_ps2_flap_decoder: directed self-checking bench for ps2_flap_decoder
module tb_ps2_flap_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_pressed = 1'b0;
    logic [7:0]  key_data = 8'h00;
    logic        flap_ack = 1'b0;
    logic        flap_req, paused;
    logic [15:0] flap_count;
    int tests = 0;
    int fails = 0;

    ps2_flap_decoder #(.HOLDOFF(24'd10), .PREFIX_TIMEOUT(20'd8)) dut (
        .clock(clock), .reset(reset), .key_pressed(key_pressed), .key_data(key_data),
        .flap_ack(flap_ack), .flap_req(flap_req), .paused(paused), .flap_count(flap_count)
    );

    always #5 clock = ~clock;

    task automatic send(input logic [7:0] b);
        key_pressed = 1'b1;
        key_data = b;
        @(posedge clock); #1;
        key_pressed = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic ack_and_settle();
        flap_ack = 1'b1;
        idle(1);
        flap_ack = 1'b0;
        idle(20);
    endtask

    task automatic test_reset();
        #3;
        tests++; if (flap_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%0b exp=0", flap_req); end
        tests++; if (paused !== 1'b0) begin fails++; $display("FAIL reset_paused got=%0b exp=0", paused); end
        tests++; if (flap_count !== 16'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", flap_count); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        send(8'h29);
        tests++; if (flap_req !== 1'b1) begin fails++; $display("FAIL basic_req got=%0b exp=1", flap_req); end
        tests++; if (flap_count !== 16'd1) begin fails++; $display("FAIL basic_count got=%0d exp=1", flap_count); end
        idle(20);
        tests++; if (flap_req !== 1'b1) begin fails++; $display("FAIL basic_hold got=%0b exp=1", flap_req); end
        flap_ack = 1'b1;
        idle(1);
        flap_ack = 1'b0;
        tests++; if (flap_req !== 1'b0) begin fails++; $display("FAIL basic_ack got=%0b exp=0", flap_req); end
        tests++; if (flap_count !== 16'd1) begin fails++; $display("FAIL basic_count_ack got=%0d exp=1", flap_count); end
        send(8'hF0); send(8'h29);
        idle(20);
    endtask

    task automatic test_autorepeat();
        send(8'h29); send(8'h29); send(8'h29);
        tests++; if (flap_count !== 16'd2) begin fails++; $display("FAIL repeat_count got=%0d exp=2", flap_count); end
        send(8'hF0); send(8'h29);
        idle(20);
        send(8'h29);
        tests++; if (flap_count !== 16'd3) begin fails++; $display("FAIL repeat_second got=%0d exp=3", flap_count); end
        send(8'hF0); send(8'h29);
        ack_and_settle();
        tests++; if (flap_req !== 1'b0) begin fails++; $display("FAIL repeat_ack got=%0b exp=0", flap_req); end
    endtask

    task automatic test_holdoff();
        send(8'h29); send(8'hF0); send(8'h29); send(8'h29);
        tests++; if (flap_count !== 16'd4) begin fails++; $display("FAIL holdoff_reject got=%0d exp=4", flap_count); end
        idle(20);
        send(8'hF0); send(8'h29); send(8'h29);
        tests++; if (flap_count !== 16'd5) begin fails++; $display("FAIL holdoff_after got=%0d exp=5", flap_count); end
        send(8'hF0); send(8'h29);
        ack_and_settle();
    endtask

    task automatic test_extended();
        send(8'hE0); send(8'h29);
        send(8'hE0); send(8'hF0); send(8'h29);
        tests++; if (flap_count !== 16'd5) begin fails++; $display("FAIL ext_nomake got=%0d exp=5", flap_count); end
        tests++; if (flap_req !== 1'b0) begin fails++; $display("FAIL ext_req got=%0b exp=0", flap_req); end
        send(8'h29);
        tests++; if (flap_count !== 16'd6) begin fails++; $display("FAIL ext_follow got=%0d exp=6", flap_count); end
        idle(20);
        send(8'hE0); send(8'hF0); send(8'h29); send(8'h29);
        tests++; if (flap_count !== 16'd6) begin fails++; $display("FAIL ext_break_held got=%0d exp=6", flap_count); end
        send(8'hF0); send(8'h29);
        ack_and_settle();
    endtask

    task automatic test_timeout();
        send(8'hF0);
        idle(10);
        send(8'h29);
        tests++; if (flap_count !== 16'd7) begin fails++; $display("FAIL timeout_make got=%0d exp=7", flap_count); end
        tests++; if (flap_req !== 1'b1) begin fails++; $display("FAIL timeout_req got=%0b exp=1", flap_req); end
        send(8'hF0); send(8'h29);
        ack_and_settle();
    endtask

    task automatic test_pause();
        send(8'h4D);
        tests++; if (paused !== 1'b1) begin fails++; $display("FAIL pause_on got=%0b exp=1", paused); end
        send(8'h4D);
        tests++; if (paused !== 1'b1) begin fails++; $display("FAIL pause_repeat got=%0b exp=1", paused); end
        send(8'hF0); send(8'h4D); send(8'h4D);
        tests++; if (paused !== 1'b0) begin fails++; $display("FAIL pause_off got=%0b exp=0", paused); end
        send(8'hF0); send(8'h4D); send(8'h4D);
        send(8'h29);
        tests++; if (flap_req !== 1'b0) begin fails++; $display("FAIL pause_noflap got=%0b exp=0", flap_req); end
        tests++; if (flap_count !== 16'd7) begin fails++; $display("FAIL pause_count got=%0d exp=7", flap_count); end
        send(8'hF0); send(8'h29);
        send(8'hF0); send(8'h4D); send(8'h4D); send(8'hF0); send(8'h4D);
        tests++; if (paused !== 1'b0) begin fails++; $display("FAIL pause_resume got=%0b exp=0", paused); end
        idle(20);
    endtask

    task automatic test_back_to_back();
        send(8'h29); send(8'hF0); send(8'h29);
        tests++; if (flap_count !== 16'd8) begin fails++; $display("FAIL b2b_count got=%0d exp=8", flap_count); end
        idle(20);
        flap_ack = 1'b1;
        send(8'h29);
        flap_ack = 1'b0;
        tests++; if (flap_req !== 1'b1) begin fails++; $display("FAIL ack_collide_req got=%0b exp=1", flap_req); end
        tests++; if (flap_count !== 16'd9) begin fails++; $display("FAIL ack_collide_count got=%0d exp=9", flap_count); end
        send(8'hF0); send(8'h29);
    endtask

    task automatic test_async_reset();
        send(8'h4D); send(8'hF0); send(8'h4D);
        tests++; if (paused !== 1'b1 || flap_req !== 1'b1) begin fails++; $display("FAIL areset_pre got=%0b%0b exp=11", paused, flap_req); end
        #3 reset = 1'b1;
        #1;
        tests++; if (flap_req !== 1'b0) begin fails++; $display("FAIL areset_req got=%0b exp=0", flap_req); end
        tests++; if (paused !== 1'b0) begin fails++; $display("FAIL areset_paused got=%0b exp=0", paused); end
        tests++; if (flap_count !== 16'd0) begin fails++; $display("FAIL areset_count got=%0d exp=0", flap_count); end
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;
        send(8'h29);
        tests++; if (flap_req !== 1'b1) begin fails++; $display("FAIL areset_after_req got=%0b exp=1", flap_req); end
        tests++; if (flap_count !== 16'd1) begin fails++; $display("FAIL areset_after_count got=%0d exp=1", flap_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_autorepeat();
        test_holdoff();
        test_extended();
        test_timeout();
        test_pause();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_flap_decoder.md
# ps2_flap_decoder

Converts the raw PS/2 scan-code byte stream (`ps2_key_pressed` strobe plus `ps2_out` byte from the PS/2 interface) into clean game-control events for the processor. It sits between the keyboard controller and the processor. It emits one held-until-acknowledged flap request per physical spacebar press and a pause toggle level. It removes typematic auto-repeat, extended (E0) codes, break sequences and over-rapid presses.

## Interface
- `FLAP_CODE`, 8'h29, make code that requests a flap (space)
- `PAUSE_CODE`, 8'h4D, make code that toggles pause ('P')
- `HOLDOFF`, 24'd1_000_000, minimum cycles between accepted flaps (100 ms at 10 MHz)
- `PREFIX_TIMEOUT`, 20'd100_000, cycles a prefix state waits for its next byte
- `clock`  in  1  processor clock (10 MHz); single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `key_pressed`  in  1  one-cycle strobe: `key_data` holds a new byte
- `key_data`  in  8  scan-code byte, valid only when `key_pressed`=1
- `flap_ack`  in  1  processor consumed the pending flap
- `flap_req`  out  1  flap pending; held until acknowledged
- `paused`  out  1  pause level, toggled per accepted pause press
- `flap_count`  out  16  accepted flaps since reset, wraps at 16'hFFFF→0

## Operation
- Prefix FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). The FSM advances only on `key_pressed`.
- In IDLE:
  - F0→BRK; E0→EXT.
  - Any other byte is a make code, then stay in IDLE.
- In BRK: the byte is a break code. Clear the held flag for that code and return to IDLE.
- In EXT:
  - F0→EXT_BRK.
  - Any other byte is ignored, then go to IDLE.
- In EXT_BRK: the byte is ignored, then go to IDLE. Extended codes never affect any flag.
- Prefix timeout: an idle counter runs in BRK, EXT and EXT_BRK and resets on every strobe. When it reaches `PREFIX_TIMEOUT`, go to IDLE with no side effects.
- Flap make handling:
  - Accepted only when `flap_held`=0, `paused`=0 and holdoff=0.
  - Acceptance sets `flap_held`, sets `flap_req`, increments `flap_count` and loads holdoff=`HOLDOFF`.
  - If `flap_held`=0 but the make is rejected (holdoff≠0 or paused), still set `flap_held`. A press is never deferred.
  - If `flap_req` is already 1, an accepted press is coalesced: count increments, `flap_req` stays 1.
- Pause make handling: if `pause_held`=0, toggle `paused` and set `pause_held`. Repeats are ignored.
- Holdoff counter decrements by 1 per cycle toward 0 and saturates at 0.
- Break code for FLAP_CODE or PAUSE_CODE clears the matching held flag. Other codes are ignored.

## Timing
- Reset values:
  - Outputs: `flap_req`=0, `paused`=0, `flap_count`=0.
  - Internal: FSM=IDLE, held flags=0, holdoff=0, timeout counter=0.
- A reset assertion mid-request clears everything immediately (asynchronous).
- Latency: a strobe sampled at edge N updates `flap_req`, `paused` and `flap_count` as registered values after edge N.
- `flap_req` handshake:
  - When `flap_ack`=1 is sampled with `flap_req`=1, `flap_req`=0 on the next cycle.
  - Ack while `flap_req`=0 is ignored.
- Simultaneous ack and accepted flap in the same cycle: `flap_req` stays 1 (the new event wins) and count increments.
- Back-to-back strobes on consecutive cycles are all processed, one byte per cycle.

## Structure
- Shared package `ps2_pkg`:
  - Constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_SPACE=8'h29, SC_P=8'h4D.
  - Prefix state enum {IDLE, BRK, EXT, EXT_BRK}, also reused by future key decoders.
- Sub-module `key_tracker`, instantiated twice (flap, pause):
  - Inputs: make and break strobes for one code.
  - Holds the held flag and outputs a one-cycle `press` pulse on the first make only.
- The top level holds the FSM, timeout counter, holdoff counter, handshake and counters.

## Test plan
- Reset, then strobe 29 → `flap_req`=1 the next cycle and stays 1 for 20 cycles without ack. Ack for 1 cycle → `flap_req`=0 the following cycle, `flap_count`=1.
- HOLDOFF=10: strobes 29,29,29 (auto-repeat), F0,29, wait 20 cycles, 29 → exactly 2 accepted flaps, `flap_count`=2.
- HOLDOFF=10: 29, F0,29, 29 within 5 cycles → second press rejected, count=1. After 20 more cycles, F0,29,29 → count=2.
- E0,29 and E0,F0,29 → no flap, no change to held flags. Following 29 → flap accepted.
- PREFIX_TIMEOUT=8: F0, idle 10 cycles, 29 → treated as make, flap accepted. 4D, F0,4D, 4D → `paused` goes 1 then 0. While `paused`=1, 29 → no flap.
- `flap_req`=1, then assert `reset` asynchronously mid-cycle → all outputs 0 before the next edge. After release, 29 → normal flap.
